// File: rtl/vmicro16_timer_multi_apb.sv
// vmicro16_timer_multi_apb - multi-channel APB timer peripheral.
//
// CHANNELS independent down-counters. Each channel has its own LOAD, CTRL, PRES and
// STATUS registers. A channel runs in periodic or one-shot mode. It keeps a sticky
// pending flag, which a write-1 to STATUS bit 0 clears.
//
// Optional feature: define VMICRO16_TIMER_CHAIN_EN to make CTRL bit 4 (CHAIN) writable
// on channels 1..CHANNELS-1. A chained channel ticks on channel n-1's expire pulse
// instead of on its own prescaler.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   S_PADDR    {channel, reg[1:0]}; reg 0 LOAD, 1 CTRL, 2 PRES, 3 STATUS/COUNT
//   S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA   APB slave request
//   S_PRDATA   combinational read data (0 when no access in progress)
//   S_PREADY   zero-wait-state ready (= PSELx & PENABLE)
//   irq        per-channel pending & IRQ_EN
//   irq_any    OR of irq
//   expire     1-cycle pulse on each channel expiry
//
// CTRL layout: b0 START, b1 ONESHOT, b2 IRQ_EN, b3 RELOAD (write-only strobe),
//              b4 CHAIN, b15 pending (read-only).
module vmicro16_timer_multi_apb #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PRES_WIDTH = 16,
  parameter string       NAME       = "TIMERM"
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(CHANNELS)+1:0]   S_PADDR,
  input  logic                          S_PWRITE,
  input  logic                          S_PSELx,
  input  logic                          S_PENABLE,
  input  logic [DATA_WIDTH-1:0]         S_PWDATA,
  output logic [DATA_WIDTH-1:0]         S_PRDATA,
  output logic                          S_PREADY,
  output logic [CHANNELS-1:0]           irq,
  output logic                          irq_any,
  output logic [CHANNELS-1:0]           expire
);

  localparam int unsigned AW = $clog2(CHANNELS) + 2;

`ifdef VMICRO16_TIMER_CHAIN_EN
  localparam bit ChainEn = 1'b1;
`else
  localparam bit ChainEn = 1'b0;
`endif

  logic                                en;
  logic                                we;
  logic [AW-1:0]                       ch_idx;
  logic [1:0]                          reg_sel;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] rd_ch;

  assign en       = S_PSELx & S_PENABLE;
  assign we       = en & S_PWRITE;
  assign S_PREADY = en;
  assign ch_idx   = S_PADDR >> 2;
  assign reg_sel  = S_PADDR[1:0];
  assign irq_any  = |irq;

  // Out-of-range channel indices match no channel, so they read 0 and writes drop.
  always_comb begin
    S_PRDATA = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (en && (ch_idx == AW'(i))) S_PRDATA = rd_ch[i];
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [DATA_WIDTH-1:0] load_q, load_d, count_q, count_d, rd_val;
    logic [PRES_WIDTH-1:0] pres_q, pres_d, pc_q, pc_d;
    logic start_q, start_d, oneshot_q, oneshot_d, irq_en_q, irq_en_d;
    logic chain_q, chain_d, pending_q, pending_d, expire_q, expire_d;
    logic hit, wr_load, wr_ctrl, wr_pres, wr_stat, reload, chain_tick, tick, expiry;

    assign hit     = we && (ch_idx == AW'(n));
    assign wr_load = hit && (reg_sel == 2'd0);
    assign wr_ctrl = hit && (reg_sel == 2'd1);
    assign wr_pres = hit && (reg_sel == 2'd2);
    assign wr_stat = hit && (reg_sel == 2'd3);
    assign reload  = wr_ctrl && S_PWDATA[3];

    if (n == 0) begin : g_first
      assign chain_tick = 1'b0;
    end else begin : g_next
      assign chain_tick = expire[n-1];
    end

    assign tick   = start_q && (chain_q ? chain_tick : (pc_q == '0));
    // A LOAD write or RELOAD strobe replaces the count, so it suppresses the expiry.
    assign expiry = tick && (count_q == '0) && !wr_load && !reload;

    always_comb begin
      load_d    = load_q;
      count_d   = count_q;
      pres_d    = pres_q;
      pc_d      = pc_q;
      start_d   = start_q;
      oneshot_d = oneshot_q;
      irq_en_d  = irq_en_q;
      chain_d   = chain_q;
      pending_d = pending_q;
      expire_d  = 1'b0;

      if (start_q && !chain_q) pc_d = (pc_q == '0) ? pres_q : pc_q - PRES_WIDTH'(1);
      if (tick && (count_q != '0)) count_d = count_q - DATA_WIDTH'(1);
      if (wr_stat && S_PWDATA[0]) pending_d = 1'b0;
      // Expiry comes after the clear so that a simultaneous clear loses.
      if (expiry) begin
        expire_d  = 1'b1;
        pending_d = 1'b1;
        if (oneshot_q) start_d = 1'b0;
        else           count_d = load_q;
      end
      if (wr_pres) pres_d = S_PWDATA[PRES_WIDTH-1:0];
      if (wr_load) begin
        load_d  = S_PWDATA;
        count_d = S_PWDATA;
        pc_d    = pres_q;
      end
      if (wr_ctrl) begin
        start_d   = S_PWDATA[0];
        oneshot_d = S_PWDATA[1];
        irq_en_d  = S_PWDATA[2];
        chain_d   = ChainEn && (n != 0) && S_PWDATA[4];
        if (S_PWDATA[0] && !start_q) pc_d = pres_q;
        if (S_PWDATA[3]) begin
          count_d = load_q;
          pc_d    = pres_q;
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        load_q    <= '0;
        count_q   <= '0;
        pres_q    <= '0;
        pc_q      <= '0;
        start_q   <= 1'b0;
        oneshot_q <= 1'b0;
        irq_en_q  <= 1'b0;
        chain_q   <= 1'b0;
        pending_q <= 1'b0;
        expire_q  <= 1'b0;
      end else begin
        load_q    <= load_d;
        count_q   <= count_d;
        pres_q    <= pres_d;
        pc_q      <= pc_d;
        start_q   <= start_d;
        oneshot_q <= oneshot_d;
        irq_en_q  <= irq_en_d;
        chain_q   <= chain_d;
        pending_q <= pending_d;
        expire_q  <= expire_d;
      end
    end

    always_comb begin
      rd_val = '0;
      case (reg_sel)
        2'd0: rd_val = load_q;
        2'd1: begin
          rd_val[0]  = start_q;
          rd_val[1]  = oneshot_q;
          rd_val[2]  = irq_en_q;
          rd_val[4]  = chain_q;
          rd_val[15] = pending_q;
        end
        2'd2: rd_val = DATA_WIDTH'(pres_q);
        default: rd_val = count_q;
      endcase
    end

    assign rd_ch[n]  = rd_val;
    assign expire[n] = expire_q;
    assign irq[n]    = pending_q & irq_en_q;
  end

endmodule

// File: tb/tb_vmicro16_timer_multi_apb.sv
// Self-checking bench for vmicro16_timer_multi_apb. It uses five channels, so that
// channel index 5 is out of range. Expected counts and pulses come from the period
// arithmetic (load+1)*(pres+1), not from a copy of the counter logic.
module tb_vmicro16_timer_multi_apb;

  localparam int unsigned CH = 5;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = $clog2(CH) + 2;

`ifdef VMICRO16_TIMER_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic [CH-1:0] irq;
  logic          irq_any;
  logic [CH-1:0] expire;

  int checks = 0;
  int errors = 0;

  vmicro16_timer_multi_apb #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .PRES_WIDTH(16),
    .NAME      ("TIMERM")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .S_PADDR  (paddr),
    .S_PWRITE (pwrite),
    .S_PSELx  (psel),
    .S_PENABLE(penable),
    .S_PWDATA (pwdata),
    .S_PRDATA (prdata),
    .S_PREADY (pready),
    .irq      (irq),
    .irq_any  (irq_any),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count observed k cycles after the START commit edge, periodic mode.
  function automatic int unsigned per_count(int unsigned l, int unsigned r, int unsigned k);
    int unsigned p;
    p = (l + 1) * (r + 1);
    return l - (k % p) / (r + 1);
  endfunction

  function automatic bit per_expire(int unsigned l, int unsigned r, int unsigned k);
    int unsigned p;
    p = (l + 1) * (r + 1);
    return (k > 0) && (k % p == 0);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a clock edge; commits on the second following edge.
  task automatic apb_write(input int ch, input int r, input logic [DW-1:0] d);
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b0;
    paddr   = AW'((ch << 2) | r);
    pwdata  = d;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  // Zero-wait read that completes between edges without disturbing the timing.
  task automatic apb_read(input int ch, input int r, output logic [DW-1:0] d, output logic rdy);
    psel    = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = AW'((ch << 2) | r);
    #1;
    d       = prdata;
    rdy     = pready;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic stop_clear(input int ch);
    apb_write(ch, 1, 16'h0000);
    apb_write(ch, 3, 16'h0001);
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic rdy;
    checks++; if (irq !== '0 || irq_any !== 1'b0 || expire !== '0) begin
      errors++; $display("FAIL reset_outputs: irq=%b any=%b exp=%b want 0", irq, irq_any, expire);
    end
    apb_read(0, 3, d, rdy);
    checks++; if (d !== '0) begin
      errors++; $display("FAIL reset_count: got %0h want 0", d);
    end
    // ch0 LOAD=1 PRES=0 periodic with IRQ_EN: pending after the first expiry.
    apb_write(0, 0, 16'd1);
    apb_write(0, 1, 16'h0005);
    wait_cyc(3);
    checks++; if (irq[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_irq: got %b want 1", irq[0]);
    end
    apb_read(0, 3, d, rdy);
    checks++; if (d !== DW'(per_count(1, 0, 3))) begin
      errors++; $display("FAIL pre_reset_count: got %0d want %0d", d, per_count(1, 0, 3));
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (irq !== '0 || irq_any !== 1'b0 || expire !== '0) begin
      errors++; $display("FAIL async_reset_outputs: irq=%b any=%b exp=%b", irq, irq_any, expire);
    end
    apb_read(0, 3, d, rdy);
    checks++; if (d !== '0) begin
      errors++; $display("FAIL async_reset_count: got %0h want 0", d);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    wait_cyc(3);
    checks++; if (irq !== '0) begin
      errors++; $display("FAIL post_reset_irq: got %b want 0", irq);
    end
    apb_read(0, 1, d, rdy);
    checks++; if (d !== '0) begin
      errors++; $display("FAIL post_reset_ctrl: got %0h want 0", d);
    end
  endtask

  task automatic test_periodic(input int ch, input int unsigned l, input int unsigned r);
    logic [DW-1:0] d;
    logic rdy;
    int unsigned p;
    p = (l + 1) * (r + 1);
    stop_clear(ch);
    apb_write(ch, 2, DW'(r));
    apb_write(ch, 0, DW'(l));
    apb_write(ch, 1, 16'h0005);
    for (int unsigned k = 0; k <= 2 * p + 1; k++) begin
      apb_read(ch, 3, d, rdy);
      checks++; if (d !== DW'(per_count(l, r, k))) begin
        errors++; $display("FAIL periodic_count ch%0d L%0d P%0d k%0d: got %0d want %0d",
                           ch, l, r, k, d, per_count(l, r, k));
      end
      checks++; if (expire[ch] !== per_expire(l, r, k)) begin
        errors++; $display("FAIL periodic_expire ch%0d k%0d: got %b want %b",
                           ch, k, expire[ch], per_expire(l, r, k));
      end
      checks++; if (irq[ch] !== (k >= p) || irq_any !== (k >= p)) begin
        errors++; $display("FAIL periodic_irq ch%0d k%0d: irq=%b any=%b want %b",
                           ch, k, irq[ch], irq_any, (k >= p));
      end
      wait_cyc(1);
    end
    stop_clear(ch);
  endtask

  task automatic test_oneshot(input int ch, input int unsigned l, input int unsigned r,
                              input bit ie);
    logic [DW-1:0] d, want;
    logic rdy;
    int unsigned p;
    p = (l + 1) * (r + 1);
    stop_clear(ch);
    apb_write(ch, 2, DW'(r));
    apb_write(ch, 0, DW'(l));
    apb_write(ch, 1, DW'(3 | (ie << 2)));
    for (int unsigned k = 0; k <= p + 4; k++) begin
      want = (k < p) ? DW'(per_count(l, r, k)) : '0;
      apb_read(ch, 3, d, rdy);
      checks++; if (d !== want) begin
        errors++; $display("FAIL oneshot_count ch%0d k%0d: got %0d want %0d", ch, k, d, want);
      end
      checks++; if (expire[ch] !== (k == p)) begin
        errors++; $display("FAIL oneshot_expire ch%0d k%0d: got %b want %b",
                           ch, k, expire[ch], (k == p));
      end
      checks++; if (irq[ch] !== (ie && k >= p)) begin
        errors++; $display("FAIL oneshot_irq ch%0d k%0d: got %b want %b",
                           ch, k, irq[ch], (ie && k >= p));
      end
      wait_cyc(1);
    end
    want = DW'(16'h8002 | (ie << 2));
    apb_read(ch, 1, d, rdy);
    checks++; if (d !== want) begin
      errors++; $display("FAIL oneshot_ctrl ch%0d: got %0h want %0h", ch, d, want);
    end
    stop_clear(ch);
  endtask

  task automatic test_pending_clear();
    logic [DW-1:0] d;
    logic rdy;
    stop_clear(0);
    apb_write(0, 2, 16'd0);
    apb_write(0, 0, 16'd3);
    apb_write(0, 1, 16'h0005);
    wait_cyc(6);
    checks++; if (irq[0] !== 1'b1) begin
      errors++; $display("FAIL clear_pre_irq: got %b want 1", irq[0]);
    end
    // Commits on the edge of the second expiry: the expiry keeps pending set.
    apb_write(0, 3, 16'h0001);
    checks++; if (expire[0] !== 1'b1 || irq[0] !== 1'b1) begin
      errors++; $display("FAIL clear_vs_expiry: exp=%b irq=%b want 1 1", expire[0], irq[0]);
    end
    apb_read(0, 1, d, rdy);
    checks++; if (d[15] !== 1'b1) begin
      errors++; $display("FAIL clear_vs_expiry_pending: got %b want 1", d[15]);
    end
    apb_write(0, 1, 16'h0004);
    apb_write(0, 3, 16'h0001);
    checks++; if (irq_any !== 1'b0 || irq !== '0) begin
      errors++; $display("FAIL clear_irq_any: any=%b irq=%b want 0", irq_any, irq);
    end
    apb_read(0, 1, d, rdy);
    checks++; if (d !== 16'h0004) begin
      errors++; $display("FAIL clear_ctrl: got %0h want 0004", d);
    end
    stop_clear(0);
  endtask

  task automatic test_load_override();
    logic [DW-1:0] d;
    logic rdy;
    stop_clear(2);
    apb_write(2, 2, 16'd0);
    apb_write(2, 0, 16'd2);
    apb_write(2, 1, 16'h0001);
    wait_cyc(1);
    apb_read(2, 3, d, rdy);
    checks++; if (d !== 16'd1) begin
      errors++; $display("FAIL override_pre_count: got %0d want 1", d);
    end
    // Commits in the cycle where count==0 would expire.
    apb_write(2, 0, 16'd9);
    checks++; if (expire[2] !== 1'b0) begin
      errors++; $display("FAIL override_expire: got %b want 0", expire[2]);
    end
    apb_read(2, 3, d, rdy);
    checks++; if (d !== 16'd9) begin
      errors++; $display("FAIL override_count: got %0d want 9", d);
    end
    apb_read(2, 1, d, rdy);
    checks++; if (d !== 16'h0001) begin
      errors++; $display("FAIL override_ctrl: got %0h want 0001", d);
    end
    stop_clear(2);
  endtask

  task automatic test_bad_channel();
    logic [DW-1:0] d, pat;
    logic rdy;
    pat = DW'($urandom_range(16'hFFFF, 1));
    apb_write(1, 0, 16'h1234);
    for (int c = 5; c < 8; c++) apb_write(c, 0, pat);
    for (int r = 0; r < 4; r++) begin
      apb_read(5, r, d, rdy);
      checks++; if (d !== '0 || rdy !== 1'b1) begin
        errors++; $display("FAIL bad_channel_read reg%0d: data=%0h ready=%b want 0 1", r, d, rdy);
      end
    end
    apb_read(1, 0, d, rdy);
    checks++; if (d !== 16'h1234) begin
      errors++; $display("FAIL bad_channel_alias: got %0h want 1234", d);
    end
    psel = 1'b1;
    penable = 1'b0;
    paddr = AW'(4);
    #1;
    checks++; if (prdata !== '0 || pready !== 1'b0) begin
      errors++; $display("FAIL idle_bus: data=%0h ready=%b want 0 0", prdata, pready);
    end
    psel = 1'b0;
  endtask

  task automatic test_regs();
    logic [DW-1:0] d, l, r, want;
    logic rdy;
    l = DW'($urandom_range(16'hFFFF, 1));
    r = DW'($urandom_range(16'hFFFF, 16));
    apb_write(3, 0, l);
    apb_write(3, 2, r);
    apb_read(3, 0, d, rdy);
    checks++; if (d !== l) begin
      errors++; $display("FAIL reg_load: got %0h want %0h", d, l);
    end
    apb_read(3, 2, d, rdy);
    checks++; if (d !== r) begin
      errors++; $display("FAIL reg_pres: got %0h want %0h", d, r);
    end
    apb_write(3, 1, 16'hFFFF);
    want = CHAIN ? 16'h0017 : 16'h0007;
    apb_read(3, 1, d, rdy);
    checks++; if (d !== want) begin
      errors++; $display("FAIL reg_ctrl: got %0h want %0h", d, want);
    end
    apb_read(3, 3, d, rdy);
    checks++; if (d !== l) begin
      errors++; $display("FAIL reg_reload_count: got %0h want %0h", d, l);
    end
    stop_clear(3);
  endtask

  task automatic test_chain();
    logic [DW-1:0] d;
    logic rdy;
    bit want;
    apb_write(0, 1, 16'h0010);
    apb_read(0, 1, d, rdy);
    checks++; if (d !== 16'h0000) begin
      errors++; $display("FAIL chain_ch0_bit: got %0h want 0", d);
    end
    apb_write(1, 1, 16'h0010);
    apb_read(1, 1, d, rdy);
    checks++; if (d !== (CHAIN ? 16'h0010 : 16'h0000)) begin
      errors++; $display("FAIL chain_ch1_bit: got %0h want %0h", d, CHAIN ? 16'h10 : 16'h0);
    end
    stop_clear(1);
    if (CHAIN) begin
      apb_write(1, 0, 16'd2);
      apb_write(1, 1, 16'h0011);
      stop_clear(0);
      apb_write(0, 2, 16'd0);
      apb_write(0, 0, 16'd1);
      apb_write(0, 1, 16'h0001);
      // ch0 expires every 2 cycles; ch1 needs 3 of those ticks, seen one cycle later.
      for (int k = 0; k <= 20; k++) begin
        want = (k > 1) && ((k - 1) % 6 == 0);
        checks++; if (expire[1] !== want || expire[0] !== per_expire(1, 0, k)) begin
          errors++; $display("FAIL chain_expire k%0d: got %b%b want %b%b",
                             k, expire[1], expire[0], want, per_expire(1, 0, k));
        end
        wait_cyc(1);
      end
      stop_clear(0);
      stop_clear(1);
    end
  endtask

  initial begin
    wait_cyc(2);
    #1 reset = 1'b1;
    wait_cyc(1);
    test_reset();
    test_periodic(0, 3, 0);
    for (int i = 0; i < 3; i++)
      test_periodic(i % 2, $urandom_range(6, 1), $urandom_range(3, 0));
    test_oneshot(1, 1, 2, 1'b0);
    test_oneshot(1, $urandom_range(5, 1), $urandom_range(3, 0), 1'b1);
    test_pending_clear();
    test_load_override();
    test_bad_channel();
    test_regs();
    test_chain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
